// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter merging N_CH 4-phase req/ack channels onto one.
// Optional watchdog: define ARB_TIMEOUT_EN to enable timeout_err.
module rr_handshake_arbiter #(
  parameter int N_CH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_in,
  output logic [N_CH-1:0] ack_in,
  output logic            req_out,
  input  logic            ack_out,
  output logic [IW-1:0]   grant_id,
  output logic            grant_valid,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_ACK, S_RTZ
  } state_t;

  state_t          state, state_nx;
  logic [N_CH-1:0] req_s;
  logic            ack_s;
  logic [IW-1:0]   ptr, ptr_nx, nptr;
  logic [IW-1:0]   gid_nx;
  logic            gv_nx, req_nx;
  logic [N_CH-1:0] ack_nx;
  logic [IW:0]     sel;
  logic            to_hit;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req_in;
      assign ack_s = ack_out;
    end else begin : g_sync
      logic [N_CH-1:0]        req_q [SYNC_STAGES];
      logic [SYNC_STAGES-1:0] ack_q;
      // flop chains bringing req_in/ack_out into the clk domain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) req_q[i] <= '0;
          ack_q <= '0;
        end else begin
          req_q[0] <= req_in;
          ack_q[0] <= ack_out;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            req_q[i] <= req_q[i-1];
            ack_q[i] <= ack_q[i-1];
          end
        end
      end
      assign req_s = req_q[SYNC_STAGES-1];
      assign ack_s = ack_q[SYNC_STAGES-1];
    end
  endgenerate

  // first set request at or after p, wrapping; MSB flags "found"
  function automatic logic [IW:0] pick(
    input logic [N_CH-1:0] r,
    input logic [IW-1:0]   p
  );
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N_CH;
      if (r[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  assign sel  = pick(req_s, ptr);
  assign nptr = (int'(grant_id) == N_CH - 1) ? '0 : grant_id + IW'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          waiting;

  assign waiting = (state == S_REQ && !ack_s) ||
                   (state == S_RTZ && ack_s);
  assign to_hit  = waiting && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // watchdog: restarts on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else if (waiting) cnt <= cnt + CW'(1);
  end

  // sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err <= 1'b0;
    else if (to_hit) timeout_err <= 1'b1;
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      req_out     <= 1'b0;
      ack_in      <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      grant_id    <= gid_nx;
      grant_valid <= gv_nx;
      req_out     <= req_nx;
      ack_in      <= ack_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (sel[IW]) state_nx = S_REQ;
      S_REQ: begin
        if (ack_s) state_nx = S_ACK;
        else if (to_hit) state_nx = S_IDLE;
      end
      S_ACK: if (!req_s[grant_id]) state_nx = S_RTZ;
      S_RTZ: if (!ack_s || to_hit) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // next output values
  always_comb begin
    ptr_nx = ptr;
    gid_nx = grant_id;
    gv_nx  = grant_valid;
    req_nx = req_out;
    ack_nx = ack_in;
    unique case (state)
      S_IDLE: begin
        if (sel[IW]) begin
          gid_nx = sel[IW-1:0];
          gv_nx  = 1'b1;
          req_nx = 1'b1;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          ack_nx = N_CH'(1) << grant_id;
        end else if (to_hit) begin
          req_nx = 1'b0;
          gv_nx  = 1'b0;
          ptr_nx = nptr;
        end
      end
      S_ACK: if (!req_s[grant_id]) req_nx = 1'b0;
      S_RTZ: begin
        if (!ack_s || to_hit) begin
          ack_nx = '0;
          gv_nx  = 1'b0;
          ptr_nx = nptr;
        end
      end
      default: begin
        req_nx = 1'b0;
        ack_nx = '0;
        gv_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Bench for rr_handshake_arbiter: vector table, hand sequences,
// and randomized traffic against a round-robin reference model.
module tb_rr_handshake_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_in0, ack_in0, req_in2, ack_in2;
  logic       ack_out0, req_out0, gv0, te0;
  logic       ack_out2, req_out2, gv2, te2;
  logic [2:0] gid0, gid2;
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    logic [7:0] req;
    int         exp_id;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  rr_handshake_arbiter #(
    .N_CH(8), .SYNC_STAGES(0), .TIMEOUT_CYCLES(16)
  ) dut0 (
    .clk(clk), .rst(rst),
    .req_in(req_in0), .ack_in(ack_in0),
    .req_out(req_out0), .ack_out(ack_out0),
    .grant_id(gid0), .grant_valid(gv0),
    .timeout_err(te0)
  );

  rr_handshake_arbiter #(
    .N_CH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut2 (
    .clk(clk), .rst(rst),
    .req_in(req_in2), .ack_in(ack_in2),
    .req_out(req_out2), .ack_out(ack_out2),
    .grant_id(gid2), .grant_valid(gv2),
    .timeout_err(te2)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic cond(input int which, input int sel);
    logic       ro;
    logic [7:0] ai;
    ro = (which == 0) ? req_out0 : req_out2;
    ai = (which == 0) ? ack_in0 : ack_in2;
    case (sel)
      0: return ro;
      1: return ai != 8'h00;
      2: return !ro;
      default: return ai == 8'h00;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int sel,
                           input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cond(which, sel) && cyc < limit);
    if (!cond(which, sel)) begin
      checks++;
      failures++;
      $display("FAIL wait dut%0d cond%0d: not seen in %0d cycles",
               which, sel, limit);
    end
  endtask

  task automatic set_req(input int which, input logic [7:0] m);
    if (which == 0) req_in0 = m;
    else req_in2 = m;
  endtask

  task automatic set_ack(input int which, input logic v);
    if (which == 0) ack_out0 = v;
    else ack_out2 = v;
  endtask

  // one full 4-phase transaction; winner drops, others stay held
  task automatic txn(input int which, input logic [7:0] mask,
                     input int dly, output int gid,
                     output int lr, output int la);
    int         c;
    logic [7:0] oh;
    set_req(which, mask);
    wait_cond(which, 0, 50, lr);
    gid = (which == 0) ? int'(gid0) : int'(gid2);
    chk("grant_valid_hi", 32'(which == 0 ? gv0 : gv2), 32'd1);
    repeat (dly) @(negedge clk);
    set_ack(which, 1'b1);
    wait_cond(which, 1, 50, la);
    oh = 8'h01 << gid;
    chk("ack_onehot", 32'(which == 0 ? ack_in0 : ack_in2), 32'(oh));
    set_req(which, mask & ~oh);
    wait_cond(which, 2, 50, c);
    set_ack(which, 1'b0);
    wait_cond(which, 3, 50, c);
    chk("grant_valid_lo", 32'(which == 0 ? gv0 : gv2), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int         gid, lr, la, c, mptr, w;
    logic [7:0] m;

    tbl[0]  = '{8'h06, 1};
    tbl[1]  = '{8'h04, 2};
    tbl[2]  = '{8'h88, 3};
    tbl[3]  = '{8'h88, 7};
    tbl[4]  = '{8'h81, 0};
    tbl[5]  = '{8'h40, 6};
    tbl[6]  = '{8'hC0, 7};
    tbl[7]  = '{8'h20, 5};
    tbl[8]  = '{8'h03, 0};
    tbl[9]  = '{8'h03, 1};
    tbl[10] = '{8'h80, 7};

    req_in0 = '0; ack_out0 = 1'b0;
    req_in2 = '0; ack_out2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_out", 32'({req_out0, req_out2}), 32'd0);
    chk("rst_ack_in", 32'({ack_in0, ack_in2}), 32'd0);
    chk("rst_gid", 32'({gid0, gid2}), 32'd0);
    chk("rst_gv_te", 32'({gv0, gv2, te0, te2}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single request, ack 3 cycles after req_out
    txn(0, 8'h04, 3, gid, lr, la);
    chk("single_gid", gid, 2);
    chk("single_req_lat", lr, 1);
    chk("single_ack_lat", la, 1);

    // vector table, ptr starts at 3 and ends at 0
    for (int i = 0; i < 11; i++) begin
      txn(0, tbl[i].req, i % 3, gid, lr, la);
      chk($sformatf("tbl%0d_gid", i), gid, tbl[i].exp_id);
    end
    set_req(0, 8'h00);

    // fairness with all requests held
    for (int i = 0; i < 16; i++) begin
      txn(0, 8'hFF, 0, gid, lr, la);
      chk($sformatf("fair%0d_gid", i), gid, i % 8);
    end
    set_req(0, 8'h00);

    // downstream ack while idle must be ignored
    set_ack(0, 1'b1);
    repeat (3) @(negedge clk);
    chk("idle_ack_ignored",
        32'({req_out0, gv0, ack_in0}), 32'd0);
    set_ack(0, 1'b0);
    @(negedge clk);

    // randomized traffic against the round-robin model
    mptr = 0;
    for (int t = 0; t < 40; t++) begin
      m = 8'($urandom_range(1, 255));
      w = -1;
      for (int k = 0; k < 8 && w < 0; k++)
        if (m[(mptr + k) % 8]) w = (mptr + k) % 8;
      mptr = (w + 1) % 8;
      txn(0, m, int'($urandom_range(0, 3)), gid, lr, la);
      chk($sformatf("rand%0d_gid", t), gid, w);
      chk("rand_req_lat", lr, 1);
    end
    set_req(0, 8'h00);

    // synchroniser latency on the 2-stage instance
    txn(1, 8'h01, 3, gid, lr, la);
    chk("sync_gid", gid, 0);
    chk("sync_req_lat", lr, 3);
    chk("sync_ack_lat", la, 3);
    set_req(1, 8'h00);

    // reset in ACK: ch5 completes once (ptr=6), then aborted
    txn(0, 8'h20, 1, gid, lr, la);
    chk("pre_rst_gid", gid, 5);
    set_req(0, 8'h20);
    wait_cond(0, 0, 50, c);
    set_ack(0, 1'b1);
    wait_cond(0, 1, 50, c);
    rst = 1'b1;
    #1;
    chk("midrst_req_out", 32'(req_out0), 32'd0);
    chk("midrst_ack_in", 32'(ack_in0), 32'd0);
    chk("midrst_gid_gv", 32'({gid0, gv0, te0}), 32'd0);
    set_req(0, 8'h00);
    set_ack(0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(0, 8'hFF, 0, gid, lr, la);
    chk("post_rst_gid", gid, 0);
    set_req(0, 8'h00);

`ifdef ARB_TIMEOUT_EN
    // no downstream ack: watchdog fires after 16 cycles in REQ
    set_req(0, 8'h04);
    wait_cond(0, 0, 50, c);
    chk("to_gid", 32'(gid0), 32'd2);
    set_req(0, 8'h06);
    wait_cond(0, 2, 100, c);
    chk("to_cycles", c, 16);
    chk("to_err", 32'(te0), 32'd1);
    chk("to_drop", 32'({gv0, ack_in0}), 32'd0);
    txn(0, 8'h02, 1, gid, lr, la);
    chk("to_next_gid", gid, 1);
    chk("to_sticky", 32'(te0), 32'd1);
    set_req(0, 8'h00);
`else
    chk("te_tied_low", 32'({te0, te2}), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
